aes_round_ctrl: RTL and testbench

AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

---
 rtl/aes_pkg.sv | 12 +
 rtl/aes_round_cnt.sv | 28 ++
 rtl/aes_round_ctrl.sv | 98 +++++++++
 tb/tb_aes_round_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared constants and FSM state type for the AES round controller.
package aes_pkg;
    localparam int NR = 10;
    localparam int RW = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;
endpackage

// File: rtl/aes_round_cnt.sv
// Round index counter: synchronous clear/increment, async reset, terminal compare.
module aes_round_cnt #(
    parameter int NR = 10,
    parameter int RW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    output logic [RW-1:0] round,
    output logic          at_nr
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            round <= '0;
        end else if (clr) begin
            round <= '0;
        end else if (inc) begin
            round <= round + 1'b1;
        end
    end

    always_comb begin
        at_nr = (round == RW'(NR));
    end

endmodule

// File: rtl/aes_round_ctrl.sv
// AES block controller: sequences LOAD, NR ROUND cycles and a DONE pulse; Moore outputs.
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int NR = aes_pkg::NR,
    parameter int RW = aes_pkg::RW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          sel,
    output logic          state_en,
    output logic          key_en,
    output logic [RW-1:0] round,
    output logic          last_round,
    output logic          done
);

    state_t state;
    logic   clr;
    logic   inc;
    logic   at_nr;

    always_comb begin
        clr = (state == ROUND) && at_nr;
        inc = (state == LOAD) || ((state == ROUND) && !at_nr);
    end

    aes_round_cnt #(
        .NR(NR),
        .RW(RW)
    ) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .inc  (inc),
        .round(round),
        .at_nr(at_nr)
    );

    // Outputs are registered from the state being entered, so they line up with state/round.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            sel        <= 1'b0;
            state_en   <= 1'b0;
            key_en     <= 1'b0;
            last_round <= 1'b0;
            done       <= 1'b0;
        end else begin
            busy       <= 1'b0;
            sel        <= 1'b0;
            state_en   <= 1'b0;
            key_en     <= 1'b0;
            last_round <= 1'b0;
            done       <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= LOAD;
                        busy     <= 1'b1;
                        state_en <= 1'b1;
                        key_en   <= 1'b1;
                    end
                end
                LOAD: begin
                    state      <= ROUND;
                    busy       <= 1'b1;
                    sel        <= 1'b1;
                    state_en   <= 1'b1;
                    key_en     <= 1'b1;
                    last_round <= (NR == 1);
                end
                ROUND: begin
                    if (at_nr) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        busy       <= 1'b1;
                        sel        <= 1'b1;
                        state_en   <= 1'b1;
                        key_en     <= 1'b1;
                        last_round <= (round == RW'(NR - 1));
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Self-checking bench for aes_round_ctrl at NR=10 and NR=4 against a cycle-offset model.
module tb_aes_round_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       busy_a, sel_a, se_a, ke_a, last_a, done_a;
    logic [3:0] round_a;
    logic       busy_b, sel_b, se_b, ke_b, last_b, done_b;
    logic [2:0] round_b;

    int n_checks = 0;
    int n_fail   = 0;
    int ta = -1;
    int tb = -1;
    int cyc = 0;
    int done_cnt = 0;

    aes_round_ctrl #(.NR(10), .RW(4)) dut_a (
        .clk(clk), .rst(rst), .start(start), .busy(busy_a), .sel(sel_a),
        .state_en(se_a), .key_en(ke_a), .round(round_a), .last_round(last_a), .done(done_a)
    );

    aes_round_ctrl #(.NR(4), .RW(3)) dut_b (
        .clk(clk), .rst(rst), .start(start), .busy(busy_b), .sel(sel_b),
        .state_en(se_b), .key_en(ke_b), .round(round_b), .last_round(last_b), .done(done_b)
    );

    always #5 clk = ~clk;

    // t = cycles since the block was accepted: 0 = LOAD, 1..nr = rounds, nr+1 = DONE, -1 = idle.
    function automatic int next_t(input int t, input logic s, input int nr);
        if (t < 0) return s ? 0 : -1;
        if (t >= nr + 1) return -1;
        return t + 1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_dut(input string n, input int t, input int nr,
                             input logic busy, input logic sel, input logic se, input logic ke,
                             input logic [31:0] rnd, input logic last, input logic done);
        logic in_round;
        in_round = (t >= 1) && (t <= nr);
        chk({n, ".busy"},  {31'd0, busy}, {31'd0, (t >= 0) && (t <= nr)});
        chk({n, ".sel"},   {31'd0, sel},  {31'd0, in_round});
        chk({n, ".state_en"}, {31'd0, se}, {31'd0, (t >= 0) && (t <= nr)});
        chk({n, ".key_en"}, {31'd0, ke},  {31'd0, (t >= 0) && (t <= nr)});
        chk({n, ".round"}, rnd, in_round ? 32'(t) : 32'd0);
        chk({n, ".last_round"}, {31'd0, last}, {31'd0, t == nr});
        chk({n, ".done"},  {31'd0, done}, {31'd0, t == nr + 1});
    endtask

    task automatic check_all();
        check_dut("a", ta, 10, busy_a, sel_a, se_a, ke_a, {28'd0, round_a}, last_a, done_a);
        check_dut("b", tb, 4,  busy_b, sel_b, se_b, ke_b, {29'd0, round_b}, last_b, done_b);
    endtask

    task automatic cycle();
        @(posedge clk);
        if (rst) begin
            ta = -1;
            tb = -1;
        end else begin
            ta = next_t(ta, start, 10);
            tb = next_t(tb, start, 4);
        end
        cyc++;
        @(negedge clk);
        if (done_a) done_cnt++;
        check_all();
    endtask

    task automatic async_reset();
        #2 rst = 1'b1;
        #1 ta = -1;
        tb = -1;
        check_all();
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $error("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int na, nb, last_done, base;
        rst = 1'b1;
        start = 1'b0;
        #3 check_all();
        repeat (3) cycle();
        rst = 1'b0;
        repeat (5) cycle();

        // Single pulse: latency and round sequence on both instances.
        start = 1'b1;
        na = -1;
        nb = -1;
        for (int n = 1; n <= 40 && (na < 0 || nb < 0); n++) begin
            cycle();
            start = 1'b0;
            if (done_a && na < 0) na = n;
            if (done_b && nb < 0) nb = n;
        end
        chk("latency_a", na, 12);
        chk("latency_b", nb, 6);
        repeat (4) cycle();

        // Held start: back-to-back blocks every NR+3 cycles.
        start = 1'b1;
        last_done = -1;
        repeat (40) begin
            cycle();
            if (done_a) begin
                if (last_done >= 0) chk("spacing_a", cyc - last_done, 13);
                last_done = cyc;
            end
        end
        start = 1'b0;
        repeat (15) cycle();

        // Starts during ROUND 3 and during DONE are ignored.
        base = done_cnt;
        start = 1'b1;
        cycle();
        start = 1'b0;
        for (int i = 0; i < 20 && round_a != 4'd3; i++) cycle();
        chk("reach_round3", {28'd0, round_a}, 32'd3);
        start = 1'b1;
        cycle();
        start = 1'b0;
        for (int i = 0; i < 20 && !done_a; i++) cycle();
        chk("reach_done", {31'd0, done_a}, 32'd1);
        start = 1'b1;
        cycle();
        start = 1'b0;
        repeat (16) cycle();
        chk("single_done", done_cnt - base, 1);

        // Asynchronous reset at round 6 aborts; next start runs a full block.
        base = done_cnt;
        start = 1'b1;
        cycle();
        start = 1'b0;
        for (int i = 0; i < 20 && round_a != 4'd6; i++) cycle();
        chk("reach_round6", {28'd0, round_a}, 32'd6);
        async_reset();
        repeat (14) cycle();
        chk("abort_no_done", done_cnt - base, 0);
        start = 1'b1;
        na = -1;
        for (int n = 1; n <= 40 && na < 0; n++) begin
            cycle();
            start = 1'b0;
            if (done_a) na = n;
        end
        chk("latency_after_rst", na, 12);
        repeat (3) cycle();

        // Start honoured on the first edge after reset release.
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        start = 1'b1;
        cycle();
        start = 1'b0;
        chk("start_after_rst", {31'd0, busy_a}, 32'd1);
        repeat (14) cycle();

        // Random start traffic with occasional asynchronous resets.
        repeat (400) begin
            start = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 59) == 0) async_reset();
            else cycle();
        end
        start = 1'b0;
        repeat (15) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
